jk_bank_ctrl: RTL and testbench
===============================

// Module: jk_bank_ctrl
// PURPOSE
//   Command sequencer for a bank of WIDTH J-K flip-flops with enable, one cell per bit, each cell's q fed back here.
//   Decodes one command at a time into per-bit J/K/enable patterns.
//   Multi-cycle commands (count up/down by N) run one bank step per clock.
//   Sits between a command source (CPU/test FSM) and the JK register bank.
// PARAMETERS
//   WIDTH  4  bank width in bits (>=2)
//   CNT_W  4  width of step count for COUNT commands
// PORTS
//   clk        in   1        single clock; controller regs update on posedge, bank cells capture on negedge
//   reset      in   1        synchronous, active-high; controller state only, bank has its own reset
//   cmd_valid  in   1        command present
//   cmd_ready  out  1        controller accepts command (IDLE only)
//   cmd_op     in   3        opcode (see BEHAVIOUR)
//   cmd_data   in   WIDTH    LOAD value / TOGGLE mask
//   cmd_count  in   CNT_W    number of COUNT steps
//   bank_q     in   WIDTH    current bank outputs
//   bank_j     out  WIDTH    J to bank
//   bank_k     out  WIDTH    K to bank
//   bank_en    out  1        enable to every bank cell
//   busy       out  1        command in progress
//   done       out  1        one-cycle pulse, command complete
//   result     out  WIDTH    bank_q captured at completion, held until next done
//   carry      out  1        COUNT wrapped (up: 1..1->0..0; down: 0..0->1..1) at least once; valid with done
// BEHAVIOUR
//   Reset: bank_j=0, bank_k=0, bank_en=0, busy=0, done=0, result=0, carry=0, state=IDLE, cmd_ready=1.
//   All outputs registered. J/K/en driven from posedge t are captured by the bank at negedge of cycle t.
//   The new bank_q is sampled at posedge t+1.
//   Opcodes:
//     0 NOP    no bank_en
//     1 CLEAR  J=0, K=1
//     2 SET    J=1, K=0
//     3 LOAD   J=data, K=~data
//     4 TOGGLE J=K=mask
//     5 CNT_UP   J=K=up-toggle vector of bank_q: bit i set iff bits i-1..0 all 1; bit0 always set
//     6 CNT_DN   J=K=down-toggle vector: bit i set iff bits i-1..0 all 0; bit0 always set
//     7 reserved, behaves as NOP
//   Handshake: accept on cmd_valid & cmd_ready (IDLE). Op, data and count are latched.
//     cmd_ready=0 in every other state. cmd_valid outside IDLE is ignored and nothing is queued.
//   FSM:
//     IDLE  -> APPLY  for ops 1-4
//     IDLE  -> STEP   for ops 5/6 with count>0
//     IDLE  -> DONE   for NOP/7, or for COUNT with count=0 (no bank_en)
//     APPLY: bank_en=1 with pattern for exactly one cycle -> DONE
//     STEP: bank_en=1.
//       J/K are recomputed every cycle from bank_q sampled at that posedge.
//       The remaining-step counter decrements; leave for DONE after the step whose counter reaches 0.
//       carry is set if the toggle vector is all ones (wrap).
//     DONE: bank_en=0, J=K=0, done=1, result<=bank_q, busy=0 next -> IDLE
//   busy=1 in APPLY, STEP and DONE.
//   Latency from accept:
//     single op: done in cycle 2
//     COUNT n: done in cycle n+1
//     NOP: done in cycle 1
//   carry is cleared on accept and only meaningful for COUNT.
//   Reset mid-operation: next cycle bank_en=0, state=IDLE, no done pulse, bank contents untouched.
//   Bank may be at any intermediate count.
//   Outside APPLY/STEP: bank_en=0 and J=K=0 (bank holds).
// STRUCTURE
//   Shared header jk_ctrl_defs.vh: opcode localparams OP_NOP..OP_CNT_DN, state encodings ST_IDLE/APPLY/STEP/DONE.
//   Sub-module jk_step_gen (combinational):
//     inputs q[WIDTH], dir
//     outputs tog[WIDTH], wrap
//     computes the up/down toggle vector and the wrap flag. Reused by the bank self-test.
// TESTING (WIDTH=4, CNT_W=4, bank = 4 JK cells on negedge clk)
//   1 reset held 2 cycles -> bank_en=0, J=K=0000, busy=0, cmd_ready=1, result=0000.
//   2 LOAD 1010 -> cycle1 J=1010 K=0101 en=1; cycle2 done=1, result=1010, then cmd_ready=1.
//   3 bank=1110, CNT_UP count=3 -> en=1 for 3 cycles, done in cycle 4, result=0001, carry=1.
//   4 bank=0001, CNT_DN count=2 -> result=1111, carry=1; CNT_DN count=0 -> done cycle1, no en, result=1111.
//   5 bank=1010, TOGGLE 0110 with cmd_valid held high during busy -> result=1100; exactly one command executed.
//   6 CNT_UP count=8 from 0000, reset asserted in step 3 -> next cycle en=0, IDLE, no done, bank=0011 retained.

Source files
------------

// File: rtl/jk_bank_ctrl_pkg.sv
// Shared definitions for the JK bank command sequencer.
//   op_e    : command opcodes carried on cmd_op
//   state_e : sequencer states
package jk_bank_ctrl_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 3'd0,
    OP_CLEAR  = 3'd1,
    OP_SET    = 3'd2,
    OP_LOAD   = 3'd3,
    OP_TOGGLE = 3'd4,
    OP_CNT_UP = 3'd5,
    OP_CNT_DN = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_STEP  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/jk_step_gen.sv
// Counter toggle-vector generator for a bank of JK cells.
//   q    in  : current bank value
//   dir  in  : 0 = count up, 1 = count down
//   tog  out : bits to toggle for one count step
//   wrap out : step wraps the counter (all bits toggle)
module jk_step_gen #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  output logic [WIDTH-1:0] tog,
  output logic             wrap
);

  logic run_c;

  // Bit i toggles when all lower bits are 1 (up) or all 0 (down).
  always_comb begin
    tog   = '0;
    run_c = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      tog[i] = run_c;
      run_c  = run_c & (dir ? ~q[i] : q[i]);
    end
    wrap = &tog;
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command sequencer driving J/K/enable of a JK flip-flop bank.
//   clk, reset           : clock, synchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake (accepted only in IDLE)
//   cmd_op/data/count    : opcode, LOAD value or TOGGLE mask, COUNT steps
//   bank_q               : bank outputs fed back
//   bank_j/bank_k/bank_en: bank drive, captured by the bank on negedge
//   busy, done           : command in progress, completion pulse
//   result, carry        : bank value at completion, COUNT wrapped flag
module jk_bank_ctrl
  import jk_bank_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] bank_q,
  output logic [WIDTH-1:0] bank_j,
  output logic [WIDTH-1:0] bank_k,
  output logic             bank_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  state_e           state_q;
  op_e              op_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] tog_c;
  logic             wrap_c;
  logic             dir_c;

  // Direction comes from the incoming opcode on accept, from the latched one while stepping.
  always_comb begin
    dir_c = 1'b0;
    if (state_q == ST_IDLE) dir_c = (cmd_op == OP_CNT_DN);
    else                    dir_c = (op_q == OP_CNT_DN);
  end

  jk_step_gen #(.WIDTH(WIDTH)) u_step_gen (
    .q    (bank_q),
    .dir  (dir_c),
    .tog  (tog_c),
    .wrap (wrap_c)
  );

  // Sequencer: outputs are set on the edge entering the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NOP;
      cnt_q     <= '0;
      cmd_ready <= 1'b1;
      bank_j    <= '0;
      bank_k    <= '0;
      bank_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            carry     <= 1'b0;
            op_q      <= op_e'(cmd_op);
            case (op_e'(cmd_op))
              OP_CLEAR: begin
                bank_j  <= '0;
                bank_k  <= '1;
                bank_en <= 1'b1;
                state_q <= ST_APPLY;
              end
              OP_SET: begin
                bank_j  <= '1;
                bank_k  <= '0;
                bank_en <= 1'b1;
                state_q <= ST_APPLY;
              end
              OP_LOAD: begin
                bank_j  <= cmd_data;
                bank_k  <= ~cmd_data;
                bank_en <= 1'b1;
                state_q <= ST_APPLY;
              end
              OP_TOGGLE: begin
                bank_j  <= cmd_data;
                bank_k  <= cmd_data;
                bank_en <= 1'b1;
                state_q <= ST_APPLY;
              end
              OP_CNT_UP, OP_CNT_DN: begin
                if (cmd_count != '0) begin
                  // First step issued straight from the accept edge.
                  bank_j  <= tog_c;
                  bank_k  <= tog_c;
                  bank_en <= 1'b1;
                  carry   <= wrap_c;
                  cnt_q   <= cmd_count - CNT_W'(1);
                  state_q <= ST_STEP;
                end else begin
                  done    <= 1'b1;
                  result  <= bank_q;
                  state_q <= ST_DONE;
                end
              end
              default: begin
                done    <= 1'b1;
                result  <= bank_q;
                state_q <= ST_DONE;
              end
            endcase
          end
        end
        ST_APPLY: begin
          bank_j  <= '0;
          bank_k  <= '0;
          bank_en <= 1'b0;
          done    <= 1'b1;
          result  <= bank_q;
          state_q <= ST_DONE;
        end
        ST_STEP: begin
          if (cnt_q == '0) begin
            bank_j  <= '0;
            bank_k  <= '0;
            bank_en <= 1'b0;
            done    <= 1'b1;
            result  <= bank_q;
            state_q <= ST_DONE;
          end else begin
            bank_j  <= tog_c;
            bank_k  <= tog_c;
            carry   <= carry | wrap_c;
            cnt_q   <= cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed self-checking bench for jk_bank_ctrl with a 4-cell JK bank model.
module tb_jk_bank_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] T_NOP    = 3'd0;
  localparam logic [2:0] T_CLEAR  = 3'd1;
  localparam logic [2:0] T_SET    = 3'd2;
  localparam logic [2:0] T_LOAD   = 3'd3;
  localparam logic [2:0] T_TOGGLE = 3'd4;
  localparam logic [2:0] T_UP     = 3'd5;
  localparam logic [2:0] T_DN     = 3'd6;
  localparam logic [2:0] T_RSVD   = 3'd7;

  logic             clk;
  logic             reset;
  logic             bank_rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] bank_q;
  logic [WIDTH-1:0] bank_j;
  logic [WIDTH-1:0] bank_k;
  logic             bank_en;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;

  int n_checks;
  int n_errors;
  int done_cyc;
  int en_cyc;

  jk_bank_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .bank_q    (bank_q),
    .bank_j    (bank_j),
    .bank_k    (bank_k),
    .bank_en   (bank_en),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry     (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // JK bank: q+ = J & ~q | ~K & q, captured on negedge when enabled.
  always @(negedge clk) begin
    if (bank_rst)     bank_q <= '0;
    else if (bank_en) bank_q <= (bank_j & ~bank_q) | (~bank_k & bank_q);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command once ready, then follow it to its done cycle.
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] data, input logic [3:0] cnt);
    bit got;
    for (int i = 0; i < 10 && !cmd_ready; i++) tick();
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = cnt;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    done_cyc = 0;
    en_cyc   = 0;
    got      = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (bank_en) en_cyc++;
      if (done) begin
        done_cyc = i;
        got      = 1'b1;
        break;
      end
      tick();
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    bank_rst  = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_data  = '0;
    cmd_count = '0;

    // Reset state
    tick();
    tick();
    chk("rst_en",    32'(bank_en),   32'd0);
    chk("rst_j",     32'(bank_j),    32'h0);
    chk("rst_k",     32'(bank_k),    32'h0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_res",   32'(result),    32'h0);
    chk("rst_done",  32'(done),      32'd0);
    reset    = 1'b0;
    bank_rst = 1'b0;
    tick();

    // LOAD 1010 with cycle-accurate checks
    cmd_op    = T_LOAD;
    cmd_data  = 4'b1010;
    cmd_count = '0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("ld_c1_j",     32'(bank_j),    32'b1010);
    chk("ld_c1_k",     32'(bank_k),    32'b0101);
    chk("ld_c1_en",    32'(bank_en),   32'd1);
    chk("ld_c1_ready", 32'(cmd_ready), 32'd0);
    chk("ld_c1_busy",  32'(busy),      32'd1);
    tick();
    chk("ld_c2_done",  32'(done),      32'd1);
    chk("ld_c2_res",   32'(result),    32'b1010);
    chk("ld_c2_en",    32'(bank_en),   32'd0);
    chk("ld_c2_j",     32'(bank_j),    32'h0);
    tick();
    chk("ld_c3_ready", 32'(cmd_ready), 32'd1);
    chk("ld_c3_busy",  32'(busy),      32'd0);
    chk("ld_c3_done",  32'(done),      32'd0);

    // SET and CLEAR
    run_cmd(T_LOAD, 4'b0101, 4'd0);
    run_cmd(T_SET, 4'b0000, 4'd0);
    chk("set_res", 32'(result), 32'b1111);
    chk("set_lat", 32'(done_cyc), 32'd2);
    run_cmd(T_CLEAR, 4'b0000, 4'd0);
    chk("clr_res", 32'(result), 32'b0000);

    // COUNT up 3 from 1110 wraps through 0000
    run_cmd(T_LOAD, 4'b1110, 4'd0);
    chk("ld1110_lat", 32'(done_cyc), 32'd2);
    run_cmd(T_UP, 4'b0000, 4'd3);
    chk("up3_lat",   32'(done_cyc), 32'd4);
    chk("up3_en",    32'(en_cyc),   32'd3);
    chk("up3_res",   32'(result),   32'b0001);
    chk("up3_carry", 32'(carry),    32'd1);
    chk("up3_bank",  32'(bank_q),   32'b0001);

    // COUNT up without wrap keeps carry low
    run_cmd(T_LOAD, 4'b0000, 4'd0);
    run_cmd(T_UP, 4'b0000, 4'd2);
    chk("up2_res",   32'(result), 32'b0010);
    chk("up2_carry", 32'(carry),  32'd0);

    // COUNT down 2 from 0001, then count 0
    run_cmd(T_LOAD, 4'b0001, 4'd0);
    run_cmd(T_DN, 4'b0000, 4'd2);
    chk("dn2_lat",   32'(done_cyc), 32'd3);
    chk("dn2_res",   32'(result),   32'b1111);
    chk("dn2_carry", 32'(carry),    32'd1);
    run_cmd(T_DN, 4'b0000, 4'd0);
    chk("dn0_lat",   32'(done_cyc), 32'd1);
    chk("dn0_en",    32'(en_cyc),   32'd0);
    chk("dn0_res",   32'(result),   32'b1111);
    chk("dn0_carry", 32'(carry),    32'd0);

    // NOP and reserved opcode: immediate done, bank untouched
    run_cmd(T_NOP, 4'b0101, 4'd5);
    chk("nop_lat",  32'(done_cyc), 32'd1);
    chk("nop_en",   32'(en_cyc),   32'd0);
    run_cmd(T_RSVD, 4'b0101, 4'd5);
    chk("rsvd_lat",  32'(done_cyc), 32'd1);
    chk("rsvd_bank", 32'(bank_q),   32'b1111);

    // TOGGLE with cmd_valid held through busy: only one command runs
    run_cmd(T_LOAD, 4'b1010, 4'd0);
    tick();
    cmd_op    = T_TOGGLE;
    cmd_data  = 4'b0110;
    cmd_count = '0;
    cmd_valid = 1'b1;
    tick();
    en_cyc   = 0;
    done_cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      if (bank_en) en_cyc++;
      if (done) begin
        done_cyc = i;
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
    chk("tg_lat", 32'(done_cyc), 32'd2);
    chk("tg_res", 32'(result),   32'b1100);
    chk("tg_en",  32'(en_cyc),   32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("tg_bank", 32'(bank_q), 32'b1100);
    chk("tg_busy", 32'(busy),   32'd0);

    // COUNT up 8 from 0000 interrupted by reset during step 3
    run_cmd(T_LOAD, 4'b0000, 4'd0);
    for (int i = 0; i < 10 && !cmd_ready; i++) tick();
    cmd_op    = T_UP;
    cmd_data  = '0;
    cmd_count = 4'd8;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("rs_c3_en",   32'(bank_en), 32'd1);
    chk("rs_c3_bank", 32'(bank_q),  32'b0010);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_en",    32'(bank_en),   32'd0);
    chk("rs_busy",  32'(busy),      32'd0);
    chk("rs_done",  32'(done),      32'd0);
    chk("rs_ready", 32'(cmd_ready), 32'd1);
    chk("rs_bank",  32'(bank_q),    32'b0011);
    tick();
    chk("rs2_done", 32'(done),   32'd0);
    chk("rs2_en",   32'(bank_en), 32'd0);
    chk("rs2_bank", 32'(bank_q), 32'b0011);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
